// File: rtl/or_share_arb.sv
// or_share_arb: four requesters share one registered A|B unit via an IDLE -> GRANT -> EXEC sequence.
// Build option OR_SHARE_ARB_RR_EN selects round-robin arbitration; otherwise req[0] has fixed top priority.
module or_share_arb #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_bus,
  input  logic [4*WIDTH-1:0] b_bus,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic [1:0]         y_id,
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for a request; winner picked here only
  // GRANT | gnt pulse to winner; its operands are captured
  // EXEC  | result registered, y_valid pulses in the following cycle
  typedef enum logic [1:0] {IDLE, GRANT, EXEC} state_e;

  state_e           state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic [1:0]       sel;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       y_id_q;
  logic             y_valid_q;

`ifdef OR_SHARE_ARB_RR_EN
  logic [1:0] ptr_q;
  logic [1:0] idx;

  // Scan from farthest (ptr itself) to nearest so the closest requester after ptr wins.
  always_comb begin
    sel = ptr_q;
    idx = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) sel = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd3;
    end else if (state_q == IDLE && req != 4'b0000) begin
      ptr_q <= sel;
    end
  end
`else
  always_comb begin
    sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) sel = 2'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    gnt     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          win_d   = sel;
        end
      end
      GRANT: begin
        gnt     = 4'b0001 << win_q;
        state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      y_id_q    <= 2'd0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      y_valid_q <= (state_q == EXEC);
      if (state_q == GRANT) begin
        a_q <= a_bus[int'(win_q)*WIDTH +: WIDTH];
        b_q <= b_bus[int'(win_q)*WIDTH +: WIDTH];
      end
      if (state_q == EXEC) begin
        y_q    <= a_q | b_q;
        y_id_q <= win_q;
      end
    end
  end

  assign y       = y_q;
  assign y_id    = y_id_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_or_share_arb.sv
// Bench for or_share_arb: directed scenarios plus random traffic, checked every cycle against
// a transaction-timeline model (grant at N, capture at N+1, result visible at N+2).
module tb_or_share_arb;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req = 4'b0000;
  logic [4*W-1:0] a_bus = '0;
  logic [4*W-1:0] b_bus = '0;
  logic [3:0]     gnt;
  logic [W-1:0]   y;
  logic           y_valid;
  logic [1:0]     y_id;
  logic           busy;

  or_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .y(y), .y_valid(y_valid), .y_id(y_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: e counts rising edges out of reset; an operation accepted at edge N owns
  // gnt during interval N, EXEC during N+1 and y_valid during N+2.
  int           e = 0;
  int           gnt_at = -100;
  int           valid_at = -100;
  int           free_at = 0;
  int           m_w = 0;
  int           m_id = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_y = '0;

`ifdef OR_SHARE_ARB_RR_EN
  int m_ptr = 3;
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction
`else
  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return i;
    end
    return 0;
  endfunction
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_at   <= -100;
      valid_at <= -100;
      free_at  <= 0;
      m_y      <= '0;
      m_id     <= 0;
`ifdef OR_SHARE_ARB_RR_EN
      m_ptr    <= 3;
`endif
    end else begin
      if (e == gnt_at) m_res <= a_bus[m_w*W +: W] | b_bus[m_w*W +: W];
      if (e == gnt_at + 1) begin
        m_y  <= m_res;
        m_id <= m_w;
      end
      if (e + 1 >= free_at && req != 4'b0000) begin
`ifdef OR_SHARE_ARB_RR_EN
        m_w   <= pick(req, m_ptr);
        m_ptr <= pick(req, m_ptr);
`else
        m_w   <= pick(req);
`endif
        gnt_at   <= e + 1;
        valid_at <= e + 3;
        free_at  <= e + 4;
      end
      e <= e + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic [3:0] eg;
    eg = (e == gnt_at) ? (4'b0001 << m_w) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("y_valid", 32'(y_valid), 32'(e == valid_at));
    chk("busy", 32'(busy), 32'((e == gnt_at) || (e == gnt_at + 1)));
    chk("y", 32'(y), 32'(m_y));
    chk("y_id", 32'(y_id), 32'(m_id));
  endtask

  task automatic step();
    @(negedge clk);
    compare();
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_y_valid"}, 32'(y_valid), 0);
    chk({tag, "_y_id"}, 32'(y_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Called at a falling edge: asserts reset mid-cycle, checks outputs clear at once.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 zero_checks(tag);
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  int order_exp[5];
  int n_gnt;
  int last_cyc;
  int w_seen;
  int bad2;
  logic [3:0] r;

  initial begin
`ifdef OR_SHARE_ARB_RR_EN
    order_exp = '{0, 1, 2, 3, 0};
`else
    order_exp = '{0, 0, 0, 0, 0};
`endif
    @(negedge clk);
    @(negedge clk);
    zero_checks("reset");
    rst_n = 1'b1;
    step();

    // single request with literal result
    req = 4'b0010; a_bus[7:4] = 4'hA; b_bus[7:4] = 4'h5;
    step(); chk("t029_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step(); chk("t029_busy_exec", 32'(busy), 1);
    step(); chk("t029_y", 32'(y), 32'hF); chk("t029_id", 32'(y_id), 1);
    chk("t029_valid", 32'(y_valid), 1);
    step(); chk("t029_valid_drop", 32'(y_valid), 0);

    // all requesters held: grant order and 3-cycle spacing
    pulse_reset("rst030");
    req = 4'hF; n_gnt = 0; last_cyc = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (gnt != 4'b0000) begin
        w_seen = 0;
        for (int i = 0; i < 4; i++) if (gnt[i]) w_seen = i;
        if (n_gnt < 5) chk("t030_order", 32'(w_seen), 32'(order_exp[n_gnt]));
        if (n_gnt > 0) chk("t030_gap", 32'(c - last_cyc), 3);
        last_cyc = c;
        n_gnt++;
      end
    end
    chk("t030_count", 32'(n_gnt), 5);
    req = 4'b0000;
    step();

    // operand change after capture
    req = 4'b0001; a_bus[3:0] = 4'h3; b_bus[3:0] = 4'h4;
    step(); chk("t031_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step(); a_bus[3:0] = 4'hF; b_bus[3:0] = 4'h8;
    step(); chk("t031_y", 32'(y), 32'h7); chk("t031_valid", 32'(y_valid), 1);
    step();

    // request withdrawn while busy
    req = 4'b0001;
    step(); req = 4'b0100;
    step(); req = 4'b0000;
    bad2 = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (gnt[2] || (y_valid && y_id == 2'd2)) bad2++;
    end
    chk("t032_no_grant2", 32'(bad2), 0);

    // reset in EXEC aborts the operation
    req = 4'b0010;
    step(); req = 4'b0000;
    step();
    pulse_reset("rst033");
    step(); chk("t033_no_valid", 32'(y_valid), 0);
    req = 4'b1000; a_bus[15:12] = 4'h9; b_bus[15:12] = 4'h2;
    step(); chk("t033_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    step(); step();
    chk("t033_y", 32'(y), 32'hB); chk("t033_id", 32'(y_id), 3);

    // idle hold
    for (int c = 0; c < 10; c++) begin
      a_bus = 16'($urandom); b_bus = 16'($urandom);
      step();
      chk("t034_y", 32'(y), 32'hB); chk("t034_id", 32'(y_id), 3);
      chk("t034_valid", 32'(y_valid), 0); chk("t034_busy", 32'(busy), 0);
    end

    // random traffic
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) r[i] = 1'b0;
        else if (!r[i]) r[i] = ($urandom_range(3) == 0);
        else if ($urandom_range(15) == 0) r[i] = 1'b0;
      end
      req = r;
      a_bus = 16'($urandom);
      b_bus = 16'($urandom);
      if ($urandom_range(149) == 0) begin
        pulse_reset("rst_rand");
        r = 4'b0000;
        req = r;
      end
    end
    req = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
